// File: rtl/dbg_run_controller.sv
// dbg_run_controller: host run-control and program loader for the
// 8-bit multicycle core, with a watchdog for wedged instructions.
module dbg_run_controller #(
    parameter int CNT_W      = 16,
    parameter int WDT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [7:0]       cmd_addr,
    input  logic [7:0]       cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic [CNT_W-1:0] inst_count,
    output logic             cpu_run,
    output logic [7:0]       cpu_pc_set_val,
    output logic             cpu_pc_set_wr,
    output logic             cpu_rst,
    input  logic             cpu_halt,
    input  logic             cpu_done,
    input  logic [7:0]       cpu_mem_addr,
    input  logic [7:0]       cpu_mem_din,
    input  logic             cpu_mem_we,
    output logic [7:0]       cpu_mem_dout,
    output logic [7:0]       mem_addr,
    output logic [7:0]       mem_din,
    output logic             mem_we,
    input  logic [7:0]       mem_dout
);

    localparam logic [2:0] OP_MEM_WR = 3'd0;
    localparam logic [2:0] OP_MEM_RD = 3'd1;
    localparam logic [2:0] OP_SET_PC = 3'd2;
    localparam logic [2:0] OP_STEP   = 3'd3;
    localparam logic [2:0] OP_RUN    = 3'd4;
    localparam logic [2:0] OP_STOP   = 3'd5;

    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_START,
        S_RUN,
        S_RSP
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] inst_count_q, inst_count_d;
    logic             limited_q, limited_d;
    logic             stop_req_q, stop_req_d;
    logic             err_q, err_d;
    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic [15:0]      run_arg;
    logic             accept;

    assign rsp_valid      = (state_q == S_RSP);
    assign rsp_data       = rsp_data_q;
    assign inst_count     = inst_count_q;
    assign cpu_pc_set_val = data_q;
    assign cpu_mem_dout   = mem_dout;

    // Next-state, handshake, memory mux and core control.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        addr_d        = addr_q;
        data_d        = data_q;
        remaining_d   = remaining_q;
        inst_count_d  = inst_count_q;
        limited_d     = limited_q;
        stop_req_d    = stop_req_q;
        err_d         = err_q;
        wdt_d         = wdt_q;
        rsp_data_d    = rsp_data_q;
        cmd_ready     = 1'b0;
        cpu_run       = 1'b0;
        cpu_pc_set_wr = 1'b0;
        cpu_rst       = 1'b0;
        mem_addr      = addr_q;
        mem_din       = data_q;
        mem_we        = 1'b0;
        run_arg       = {cmd_addr, cmd_data};
        accept        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready = !rst;
                accept    = cmd_valid && cmd_ready;
                if (accept) begin
                    op_d   = cmd_op;
                    addr_d = cmd_addr;
                    data_d = cmd_data;
                    case (cmd_op)
                        OP_MEM_WR, OP_MEM_RD, OP_SET_PC: begin
                            state_d = S_ACCESS;
                        end
                        OP_STEP: begin
                            remaining_d = CNT_W'(1);
                            limited_d   = 1'b1;
                            state_d     = S_START;
                        end
                        OP_RUN: begin
                            remaining_d = CNT_W'(run_arg);
                            limited_d   = (run_arg != 16'h0000);
                            state_d     = S_START;
                        end
                        default: begin
                            rsp_data_d = {cpu_halt, err_q, 6'b0};
                            state_d    = S_RSP;
                        end
                    endcase
                end
            end
            S_ACCESS: begin
                rsp_data_d = 8'h00;
                case (op_q)
                    OP_MEM_WR: mem_we = 1'b1;
                    OP_MEM_RD: rsp_data_d = mem_dout;
                    OP_SET_PC: cpu_pc_set_wr = 1'b1;
                    default: ;
                endcase
                state_d = S_RSP;
            end
            S_START: begin
                cpu_run      = 1'b1;
                inst_count_d = '0;
                wdt_d        = '0;
                stop_req_d   = 1'b0;
                state_d      = S_RUN;
            end
            S_RUN: begin
                mem_addr  = cpu_mem_addr;
                mem_din   = cpu_mem_din;
                mem_we    = cpu_mem_we;
                cpu_run   = !stop_req_q &&
                            !(limited_q && remaining_q == CNT_W'(1));
                cmd_ready = !rst && (cmd_op == OP_STOP);
                accept    = cmd_valid && cmd_ready;
                if (accept) begin
                    stop_req_d = 1'b1;
                end
                if (cpu_done) begin
                    if (inst_count_q != '1) begin
                        inst_count_d = inst_count_q + CNT_W'(1);
                    end
                    remaining_d = remaining_q - CNT_W'(1);
                    wdt_d       = '0;
                    if (!cpu_run) begin
                        rsp_data_d = inst_count_d[7:0];
                        state_d    = S_RSP;
                    end
                end else if (wdt_q == WDT_LAST) begin
                    cpu_rst    = 1'b1;
                    err_d      = 1'b1;
                    wdt_d      = '0;
                    rsp_data_d = 8'hFF;
                    state_d    = S_RSP;
                end else begin
                    wdt_d = wdt_q + WDT_W'(1);
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    if (op_q[2:1] == 2'b11) begin
                        err_d = 1'b0;
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= 3'd0;
            addr_q       <= 8'h00;
            data_q       <= 8'h00;
            remaining_q  <= '0;
            inst_count_q <= '0;
            limited_q    <= 1'b0;
            stop_req_q   <= 1'b0;
            err_q        <= 1'b0;
            wdt_q        <= '0;
            rsp_data_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            remaining_q  <= remaining_d;
            inst_count_q <= inst_count_d;
            limited_q    <= limited_d;
            stop_req_q   <= stop_req_d;
            err_q        <= err_d;
            wdt_q        <= wdt_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_dbg_run_controller.sv
// Bench for dbg_run_controller: a behavioural core and memory sit
// behind the DUT; responses are scored against a program-level model.
module tb_dbg_run_controller;

    localparam int CNT_W = 16;
    localparam int WDT   = 16;

    localparam logic [2:0] OP_WR   = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_PC   = 3'd2;
    localparam logic [2:0] OP_STEP = 3'd3;
    localparam logic [2:0] OP_RUN  = 3'd4;
    localparam logic [2:0] OP_STOP = 3'd5;
    localparam logic [2:0] OP_STAT = 3'd6;

    logic             clk, rst;
    logic             cmd_valid, cmd_ready;
    logic [2:0]       cmd_op;
    logic [7:0]       cmd_addr, cmd_data;
    logic             rsp_valid, rsp_ready;
    logic [7:0]       rsp_data;
    logic [CNT_W-1:0] inst_count;
    logic             cpu_run, cpu_pc_set_wr, cpu_rst;
    logic [7:0]       cpu_pc_set_val;
    logic             cpu_halt, cpu_done;
    logic [7:0]       cpu_mem_addr, cpu_mem_din, cpu_mem_dout;
    logic             cpu_mem_we;
    logic [7:0]       mem_addr, mem_din, mem_dout;
    logic             mem_we;

    dbg_run_controller #(.CNT_W(CNT_W), .WDT_CYCLES(WDT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .inst_count(inst_count),
        .cpu_run(cpu_run), .cpu_pc_set_val(cpu_pc_set_val),
        .cpu_pc_set_wr(cpu_pc_set_wr), .cpu_rst(cpu_rst),
        .cpu_halt(cpu_halt), .cpu_done(cpu_done),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_din(cpu_mem_din),
        .cpu_mem_we(cpu_mem_we), .cpu_mem_dout(cpu_mem_dout),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_dout(mem_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- memory ----------------
    logic [7:0] mem [256];
    assign mem_dout = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
    end

    // ---------------- behavioural core ----------------
    // Ops: 0xFF wedges; bit7 jumps to op[5:0]; else pc+1, and bit6
    // stores the pc to 0xF0. Exec takes op[1:0]+1 cycles after fetch.
    localparam logic [1:0] C_IDLE = 2'd0, C_FETCH = 2'd1, C_EXEC = 2'd2;
    logic [1:0] cst;
    logic [7:0] cpc, cop;
    logic [2:0] ccnt;
    int         fetch_cnt = 0;
    int         done_cnt = 0;

    assign cpu_halt     = (cst == C_IDLE);
    assign cpu_done     = (cst == C_EXEC) && (cop != 8'hFF) && (ccnt == 3'd0);
    assign cpu_mem_addr = (cst == C_EXEC) ? 8'hF0 : cpc;
    assign cpu_mem_din  = cpc;
    assign cpu_mem_we   = cpu_done && cop[6] && !cop[7];

    always @(posedge clk) begin
        if (rst || cpu_rst) begin
            cst  <= C_IDLE;
            cpc  <= 8'h00;
            cop  <= 8'h00;
            ccnt <= 3'd0;
        end else begin
            case (cst)
                C_IDLE: begin
                    if (cpu_pc_set_wr) cpc <= cpu_pc_set_val;
                    if (cpu_run) cst <= C_FETCH;
                end
                C_FETCH: begin
                    cop       <= cpu_mem_dout;
                    ccnt      <= {1'b0, cpu_mem_dout[1:0]};
                    cst       <= C_EXEC;
                    fetch_cnt <= fetch_cnt + 1;
                end
                default: begin
                    if (cpu_done) begin
                        cpc      <= cop[7] ? {2'b00, cop[5:0]} : cpc + 8'd1;
                        done_cnt <= done_cnt + 1;
                        cst      <= cpu_run ? C_FETCH : C_IDLE;
                    end else if (cop != 8'hFF) begin
                        ccnt <= ccnt - 3'd1;
                    end
                end
            endcase
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] mm [256];
    logic [7:0] pc_m;
    logic       err_m;

    function automatic void model_run(input int n, output logic [7:0] rsp,
                                      output int cnt);
        logic [7:0] op;
        cnt = 0;
        rsp = 8'h00;
        while (1) begin
            op = mm[pc_m];
            if (op == 8'hFF) begin
                err_m = 1'b1;
                pc_m  = 8'h00;
                rsp   = 8'hFF;
                return;
            end
            if (op[6] && !op[7]) mm[8'hF0] = pc_m;
            pc_m = op[7] ? {2'b00, op[5:0]} : pc_m + 8'd1;
            cnt++;
            if (n != 0 && cnt == n) begin
                rsp = cnt[7:0];
                return;
            end
        end
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [7:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int run_hi = 0, rst_pulses = 0, we10 = 0;
    bit hold_rdy = 1'b0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            rsp_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic [7:0] last;
        bit pend;
        pend = 1'b0;
        last = 8'h00;
        forever begin
            @(negedge clk);
            if (cpu_run) run_hi++;
            if (cpu_rst) rst_pulses++;
            if (mem_we && mem_addr == 8'h10) we10++;
            if (rst) begin
                pend = 1'b0;
            end else if (rsp_valid) begin
                if (pend) check("rsp_stable", rsp_data, last);
                if (rsp_ready) begin
                    pend = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp actual=%0h required=none",
                                 rsp_data);
                    end else begin
                        check("rsp", rsp_data, exp_q.pop_front());
                    end
                end else begin
                    pend = 1'b1;
                    last = rsp_data;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [2:0] op, input logic [7:0] a,
                            input logic [7:0] d);
        int t;
        t = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        #1;
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept_timeout actual=0 required=1");
        end else begin
            @(posedge clk);
        end
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || rsp_valid) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout actual=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_wr(input logic [7:0] a, input logic [7:0] d);
        mm[a] = d;
        exp_q.push_back(8'h00);
        send_cmd(OP_WR, a, d);
        wait_idle();
    endtask

    task automatic do_rd(input logic [7:0] a);
        exp_q.push_back(mm[a]);
        send_cmd(OP_RD, a, 8'h00);
        wait_idle();
    endtask

    task automatic do_pc(input logic [7:0] d);
        pc_m = d;
        exp_q.push_back(8'h00);
        send_cmd(OP_PC, 8'h00, d);
        wait_idle();
    endtask

    task automatic do_run(input logic [2:0] op, input int n);
        logic [7:0] r;
        int c;
        model_run(n, r, c);
        exp_q.push_back(r);
        send_cmd(op, 8'(n >> 8), 8'(n));
        wait_idle();
        check("inst_count", inst_count, c);
    endtask

    task automatic do_stat(input logic [2:0] op);
        exp_q.push_back({1'b1, err_m, 6'b0});
        if (op != OP_STOP) err_m = 1'b0;
        send_cmd(op, 8'h00, 8'h00);
        wait_idle();
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        #1 check("rst_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_cpu_run", cpu_run, 0);
        rst = 1'b0;
        #1 check("post_rst_cmd_ready", cmd_ready, 1);
        exp_q.delete();
        pc_m  = 8'h00;
        err_m = 1'b0;
    endtask

    function automatic logic [7:0] rnd_byte();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return 8'($urandom_range(0, 8'h7F));
        if (r < 8) return 8'($urandom_range(8'h80, 8'hBF));
        if (r == 8) return 8'hFF;
        return 8'($urandom_range(0, 255));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int base, b2, k, cnt;
        bit found;
        logic [7:0] prog [16];
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_addr  = 8'h00;
        cmd_data  = 8'h00;
        pc_m      = 8'h00;
        err_m     = 1'b0;
        prog = '{8'h01, 8'h02, 8'h03, 8'h40, 8'h00, 8'h41, 8'h02, 8'h01,
                 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 8'h01, 8'h02};

        @(negedge clk);
        @(negedge clk);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_inst_count", inst_count, 0);
        check("reset_cpu_run", cpu_run, 0);
        check("reset_cpu_rst", cpu_rst, 0);
        check("reset_mem_we", mem_we, 0);
        check("reset_pc_set_wr", cpu_pc_set_wr, 0);
        check("reset_cmd_ready", cmd_ready, 0);
        rst = 1'b0;
        #1 check("idle_cmd_ready", cmd_ready, 1);

        // Host write then read-back, one write strobe.
        base = we10;
        do_wr(8'h10, 8'hA5);
        do_rd(8'h10);
        check("we_cycles_0x10", we10 - base, 1);

        // Single step of a preloaded program.
        for (int i = 0; i < 16; i++) do_wr(8'(i), prog[i]);
        do_pc(8'h00);
        base = run_hi;
        do_run(OP_STEP, 1);
        check("step_run_cycles", run_hi - base, 1);
        check("step_halt", cpu_halt, 1);

        // Counted run of five, no extra fetch.
        do_pc(8'h00);
        base = fetch_cnt;
        do_run(OP_RUN, 5);
        check("run5_fetches", fetch_cnt - base, 5);
        do_rd(8'hF0);

        // Free run on a loop, stopped by the host.
        do_wr(8'h20, 8'h01);
        do_wr(8'h21, 8'h02);
        do_wr(8'h22, 8'hA0);
        do_pc(8'h20);
        hold_rdy = 1'b1;
        base = done_cnt;
        send_cmd(OP_RUN, 8'h00, 8'h00);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cmd_op = 3'($urandom_range(0, 4));
            #1 check("run_ready_nonstop", cmd_ready, 0);
        end
        @(negedge clk);
        cmd_op = OP_STOP;
        cmd_valid = 1'b1;
        #1 check("run_ready_stop", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (rsp_valid) found = 1'b1;
        end
        cnt = done_cnt - base;
        check("stop_rsp_seen", found, 1);
        check("stop_ran", cnt > 0, 1);
        check("stop_inst_count", inst_count, cnt);
        exp_q.push_back(8'(cnt));
        hold_rdy = 1'b0;
        wait_idle();
        b2 = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) b2++;
        end
        check("stop_no_rsp", b2, 0);

        // Undefined opcode trips the watchdog.
        do_wr(8'h30, 8'hFF);
        do_pc(8'h30);
        base = rst_pulses;
        exp_q.push_back(8'hFF);
        model_run(0, prog[0], cnt);
        send_cmd(OP_RUN, 8'h00, 8'h00);
        k = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (i == 0) check("wdt_start_run", cpu_run, 1);
            if (cpu_rst) begin
                k = i;
                break;
            end
        end
        check("wdt_trip_cycle", k, WDT);
        wait_idle();
        check("wdt_rst_pulses", rst_pulses - base, 1);
        check("wdt_inst_count", inst_count, cnt);
        do_stat(OP_STAT);
        do_stat(OP_STAT);

        // Reset during RUN, and during a held response.
        do_pc(8'h20);
        send_cmd(OP_RUN, 8'h00, 8'h00);
        repeat (10) @(negedge clk);
        pulse_rst();
        hold_rdy = 1'b1;
        send_cmd(OP_STAT, 8'h00, 8'h00);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (rsp_valid) found = 1'b1;
        end
        check("held_rsp_seen", found, 1);
        check("held_rsp_data", rsp_data, {1'b1, err_m, 6'b0});
        repeat (3) @(negedge clk);
        pulse_rst();
        hold_rdy = 1'b0;

        // Randomised program load and command mix.
        for (int i = 0; i < 256; i++) do_wr(8'(i), rnd_byte());
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: do_wr(8'($urandom_range(0, 255)), rnd_byte());
                3, 4:    do_rd(8'($urandom_range(0, 255)));
                5:       do_pc(8'($urandom_range(0, 8'h3F)));
                6:       do_run(OP_STEP, 1);
                7:       do_run(OP_RUN, $urandom_range(1, 6));
                8:       do_stat($urandom_range(0, 1) ? OP_STAT : 3'd7);
                default: do_stat(OP_STOP);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
